// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
// Holds the FSM encoding and the limb width.
package mp_add_pkg;
    localparam int LIMB_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/mp_add_seq_adder8.sv
// 8-bit ripple-carry adder shared by every limb of the sequencer.
// Purely combinational.
module Adder8 (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] S,
    output logic       Cout
);
    always_comb begin
        logic c;
        c = Cin;
        S = '0;
        for (int i = 0; i < 8; i++) begin
            S[i] = A[i] ^ B[i] ^ c;
            c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
        end
        Cout = c;
    end
endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract: latches WORDS-limb operands on start and
// pushes one limb per clock through a single shared 8-bit adder, LS limb first.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int W     = LIMB_W * WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op_sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_e         state_q;
    logic [W-1:0]   a_q, b_q, acc_q, sum_q;
    logic           c_q, cout_q;
    logic [IW-1:0]  idx_q;

    logic [LIMB_W-1:0] s_limb;
    logic              c_limb;
    logic [W-1:0]      acc_d;

    Adder8 u_add (
        .A    (a_q[LIMB_W-1:0]),
        .B    (b_q[LIMB_W-1:0]),
        .Cin  (c_q),
        .S    (s_limb),
        .Cout (c_limb)
    );

    // New limb enters at the top so after WORDS shifts the LS limb sits at bit 0.
    assign acc_d = (acc_q >> LIMB_W) | (W'(s_limb) << (W - LIMB_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        // Subtract as A + ~B + ~borrow_in.
                        a_q     <= a;
                        b_q     <= op_sub ? ~b : b;
                        c_q     <= cin ^ op_sub;
                        idx_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    a_q   <= a_q >> LIMB_W;
                    b_q   <= b_q >> LIMB_W;
                    c_q   <= c_limb;
                    idx_q <= idx_q + IW'(1);
                    if (idx_q == IW'(WORDS - 1)) begin
                        sum_q   <= acc_d;
                        cout_q  <= c_limb;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq: a WORDS=4 and a WORDS=1 instance checked
// against hand-computed vectors plus busy/abort/hold sequences.
module tb_mp_add_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start4, sub4, cin4, busy4, done4, cout4;
    logic [31:0] a4, b4, sum4;
    logic        start1, sub1, cin1, busy1, done1, cout1;
    logic [7:0]  a1, b1, sum1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mp_add_seq #(.WORDS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .op_sub(sub4), .a(a4), .b(b4),
        .cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    mp_add_seq #(.WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op_sub(sub1), .a(a1), .b(b1),
        .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    typedef struct {
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    // Issue one operation on the selected instance and check latency and result.
    task automatic run_op(input bit w1, input logic sub, input logic [31:0] a,
                          input logic [31:0] b, input logic c,
                          input logic [31:0] es, input logic ec, input string nm);
        int n;
        bit got;
        @(negedge clk);
        if (w1) begin
            sub1 = sub; a1 = a[7:0]; b1 = b[7:0]; cin1 = c; start1 = 1'b1;
        end else begin
            sub4 = sub; a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
        end
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
        n = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (w1 ? done1 : done4) got = 1'b1;
        end
        check({nm, " latency"}, n, w1 ? 2 : 5);
        check({nm, " sum"}, w1 ? {24'h0, sum1} : sum4, es);
        check({nm, " cout"}, w1 ? cout1 : cout4, ec);
    endtask

    initial begin
        int n;
        bit seen;
        logic [8:0] ref9;

        vecs[0] = '{1'b0, 32'h0000_00FA, 32'h0000_0009, 1'b0, 32'h0000_0103, 1'b0};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[2] = '{1'b1, 32'h0000_0005, 32'h0000_0009, 1'b0, 32'hFFFF_FFFC, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_0100, 32'h0000_0001, 1'b1, 32'h0000_00FE, 1'b1};
        vecs[4] = '{1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0};
        vecs[5] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[6] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[7] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b0};

        rst = 1'b1;
        start4 = 0; sub4 = 0; cin4 = 0; a4 = '0; b4 = '0;
        start1 = 0; sub1 = 0; cin1 = 0; a1 = '0; b1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", busy4, 0);
        check("reset done", done4, 0);
        check("reset sum", sum4, 0);
        check("reset cout", cout4, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op(1'b0, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].exp_sum, vecs[i].exp_cout, $sformatf("vec%0d", i));

        // start pulsed in RUN and in DONE with other operands must be ignored.
        @(negedge clk);
        sub4 = 0; a4 = 32'h0000_00FA; b4 = 32'h0000_0009; cin4 = 0; start4 = 1;
        @(negedge clk);
        start4 = 0;
        @(negedge clk);
        sub4 = 1; a4 = 32'h5555_5555; b4 = 32'h1111_1111; cin4 = 1; start4 = 1;
        @(negedge clk);
        start4 = 0;
        n = 0;
        while (n < 20 && !done4) begin @(negedge clk); n++; end
        check("ignore run done seen", done4, 1);
        start4 = 1;
        @(negedge clk);
        start4 = 0;
        check("ignore sum", sum4, 32'h0000_0103);
        @(negedge clk);
        check("ignore busy after done", busy4, 0);

        // start held high: re-accepted in the IDLE cycle right after done.
        sub4 = 0; a4 = 32'h0000_0001; b4 = 32'h0000_0002; cin4 = 0; start4 = 1;
        @(negedge clk);
        a4 = 32'h1000_0000; b4 = 32'h2000_0000; cin4 = 1;
        n = 0;
        while (n < 20 && !done4) begin @(negedge clk); n++; end
        check("hold first sum", sum4, 32'h0000_0003);
        n = 0;
        @(negedge clk);
        n++;
        while (n < 20 && !done4) begin @(negedge clk); n++; end
        start4 = 0;
        check("hold interval", n, 6);
        check("hold second sum", sum4, 32'h3000_0001);
        repeat (2) @(negedge clk);

        // Reset two cycles into RUN aborts with no done pulse.
        sub4 = 0; a4 = 32'hFFFF_FFFF; b4 = 32'h0000_0001; cin4 = 0; start4 = 1;
        @(posedge clk);
        #1 start4 = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("abort busy", busy4, 0);
        check("abort sum", sum4, 0);
        check("abort cout", cout4, 0);
        rst = 0;
        seen = 0;
        repeat (8) begin @(negedge clk); if (done4) seen = 1; end
        check("abort no done", seen, 0);
        run_op(1'b0, 1'b0, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, "after abort");

        // Single-limb instance.
        run_op(1'b1, 1'b0, 32'd250, 32'd9, 1'b1, 32'd4, 1'b1, "w1 250+9+1");
        run_op(1'b1, 1'b1, 32'd5, 32'd9, 1'b0, 32'hFC, 1'b0, "w1 5-9");
        for (int av = 0; av < 10; av++)
            for (int c = 0; c < 2; c++) begin
                ref9 = 9'(av) + 9'd250 + 9'(c);
                run_op(1'b1, 1'b0, 32'(av), 32'd250, c[0], {24'h0, ref9[7:0]}, ref9[8],
                       $sformatf("w1 sweep %0d+250+%0d", av, c));
            end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
